// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the shadow-pipe entry layout and the default register address width.
package pipe_hazard_ctrl_pkg;

  // Register address width of the mini core (ID/EX destination field).
  localparam int REG_ADDR_DEF = 3;

  // Number of shadow entries mirroring EX, MEM and WB.
  localparam int SH_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                    v;
    logic                    wr;
    logic [REG_ADDR_DEF-1:0] addr;
  } sh_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Source-versus-shadow comparator: flags a read-after-write conflict between
// the ID instruction's sources and one in-flight write. Purely combinational.
module pipe_hazard_ctrl_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR = REG_ADDR_DEF
) (
  input  logic                sh_wr_i,
  input  logic [REG_ADDR-1:0] sh_addr_i,
  input  logic                r1_used_i,
  input  logic [REG_ADDR-1:0] r1_addr_i,
  input  logic                r2_used_i,
  input  logic [REG_ADDR-1:0] r2_addr_i,
  output logic                hit_o
);

  // Register 0 is an ordinary register here, so no zero-address exclusion.
  always_comb begin
    hit_o = sh_wr_i & ((r1_used_i & (r1_addr_i == sh_addr_i)) |
                       (r2_used_i & (r2_addr_i == sh_addr_i)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / halt controller for the 5-stage mini core.
// Tracks writes in flight with a 3-entry shadow pipe (EX, MEM, WB), stalls
// fetch and inserts bubbles on RAW hazards (no forwarding), and drains then
// freezes the pipe on halt_req.
// Optional build macro: PIPE_STALL_CNT_EN adds the saturating stall_cnt port.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR  = REG_ADDR_DEF,
  parameter int CHK_DEPTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic                id_r1_used,
  input  logic [REG_ADDR-1:0] id_r1_addr,
  input  logic                id_r2_used,
  input  logic [REG_ADDR-1:0] id_r2_addr,
  input  logic                id_wreg_en,
  input  logic [REG_ADDR-1:0] id_wreg_addr,
  input  logic                halt_req,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                idex_en,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic                bubble,
  output logic                halted
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  if (CHK_DEPTH < 1 || CHK_DEPTH > SH_DEPTH || CNT_WIDTH < 1) begin : g_cfg_illegal
    $error("pipe_hazard_ctrl: CHK_DEPTH must be 1..3 and CNT_WIDTH at least 1");
  end

  state_e    state_q, state_d;
  sh_entry_t sh_q [SH_DEPTH];
  sh_entry_t sh_d [SH_DEPTH];

  logic [CHK_DEPTH-1:0] hit_s;
  logic                 haz_s;
  logic                 drain_empty_s;

  // One comparator per checked stage, nearest stage (EX) first.
  for (genvar gi = 0; gi < CHK_DEPTH; gi++) begin : g_cmp
    pipe_hazard_ctrl_hazard_cmp #(
      .REG_ADDR (REG_ADDR)
    ) u_cmp (
      .sh_wr_i   (sh_q[gi].wr),
      .sh_addr_i (sh_q[gi].addr),
      .r1_used_i (id_r1_used),
      .r1_addr_i (id_r1_addr),
      .r2_used_i (id_r2_used),
      .r2_addr_i (id_r2_addr),
      .hit_o     (hit_s[gi])
    );
  end

  // Hazard only matters when ID holds a real instruction.
  always_comb begin
    haz_s = id_valid & (|hit_s);
  end

  // Pipe is empty after this cycle's shift: the new EX entry is always a
  // bubble while draining, and the old WB entry falls out, so only the old
  // EX and MEM entries can still be valid.
  always_comb begin
    drain_empty_s = ~sh_q[0].v & ~sh_q[1].v;
  end

  // Mealy enables/bubble and next-state selection.
  always_comb begin
    pc_en    = 1'b0;
    ifid_en  = 1'b0;
    idex_en  = 1'b0;
    exmem_en = 1'b0;
    memwb_en = 1'b0;
    bubble   = 1'b1;
    halted   = 1'b0;
    state_d  = state_q;
    if (reset) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (haz_s) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            bubble  = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            bubble  = 1'b0;
          end
          if (halt_req) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          bubble   = 1'b1;
          if (!halt_req) begin
            state_d = ST_RUN;
          end else if (drain_empty_s) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Shifted shadow contents; a bubble enters EX as an invalid non-writer.
  always_comb begin
    sh_d[0].v    = id_valid & ~bubble;
    sh_d[0].wr   = id_valid & id_wreg_en & ~bubble;
    sh_d[0].addr = id_wreg_addr;
    sh_d[1]      = sh_q[0];
    sh_d[2]      = sh_q[1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow pipe advances with the ID/EX register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SH_DEPTH; i++) begin
      if (reset) begin
        sh_q[i] <= '0;
      end else if (idex_en) begin
        sh_q[i] <= sh_d[i];
      end else begin
        sh_q[i] <= sh_q[i];
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Count hazard stalls in RUN only; saturate instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN) && haz_s && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1'b1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a CHK_DEPTH=3 instance and a
// CHK_DEPTH=2 instance driven by directed per-cycle vectors.
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] ALL = 5'b11111;  // {pc,ifid,idex,exmem,memwb}
  localparam logic [4:0] STL = 5'b00111;
  localparam logic [4:0] NON = 5'b00000;

  logic clk;
  logic reset;

  logic       d1_valid, d1_r1u, d1_r2u, d1_we, d1_halt;
  logic [2:0] d1_r1a, d1_r2a, d1_wa;
  logic       d1_pc, d1_ifid, d1_idex, d1_exmem, d1_memwb, d1_bub, d1_hlt;
  logic       d2_valid, d2_r1u, d2_r2u, d2_we, d2_halt;
  logic [2:0] d2_r1a, d2_r2a, d2_wa;
  logic       d2_pc, d2_ifid, d2_idex, d2_exmem, d2_memwb, d2_bub, d2_hlt;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] d1_cnt, d2_cnt;
`endif

  pipe_hazard_ctrl #(.REG_ADDR(3), .CHK_DEPTH(3), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(d1_valid),
    .id_r1_used(d1_r1u), .id_r1_addr(d1_r1a),
    .id_r2_used(d1_r2u), .id_r2_addr(d1_r2a),
    .id_wreg_en(d1_we), .id_wreg_addr(d1_wa), .halt_req(d1_halt),
    .pc_en(d1_pc), .ifid_en(d1_ifid), .idex_en(d1_idex),
    .exmem_en(d1_exmem), .memwb_en(d1_memwb), .bubble(d1_bub), .halted(d1_hlt)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(d1_cnt)
`endif
  );

  pipe_hazard_ctrl #(.REG_ADDR(3), .CHK_DEPTH(2), .CNT_WIDTH(16)) u_dut2 (
    .clk(clk), .reset(reset), .id_valid(d2_valid),
    .id_r1_used(d2_r1u), .id_r1_addr(d2_r1a),
    .id_r2_used(d2_r2u), .id_r2_addr(d2_r2a),
    .id_wreg_en(d2_we), .id_wreg_addr(d2_wa), .halt_req(d2_halt),
    .pc_en(d2_pc), .ifid_en(d2_ifid), .idex_en(d2_idex),
    .exmem_en(d2_exmem), .memwb_en(d2_memwb), .bubble(d2_bub), .halted(d2_hlt)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(d2_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       sel;
    logic [4:0] en;
    logic       bub;
    logic       hlt;
    int         cnt;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Drive one cycle of stimulus on the selected DUT and queue its expectation.
  task automatic step(input logic sel, input logic rst, input logic hreq,
                      input logic v, input logic r1u, input logic [2:0] r1a,
                      input logic r2u, input logic [2:0] r2a,
                      input logic we, input logic [2:0] wa,
                      input logic [4:0] en, input logic bub, input logic hlt,
                      input int cnt, input string nm);
    exp_t e;
    reset = rst;
    d1_valid = 1'b0; d1_r1u = 1'b0; d1_r1a = 3'd0; d1_r2u = 1'b0; d1_r2a = 3'd0;
    d1_we = 1'b0; d1_wa = 3'd0; d1_halt = 1'b0;
    d2_valid = 1'b0; d2_r1u = 1'b0; d2_r1a = 3'd0; d2_r2u = 1'b0; d2_r2a = 3'd0;
    d2_we = 1'b0; d2_wa = 3'd0; d2_halt = 1'b0;
    if (sel == 1'b0) begin
      d1_valid = v; d1_r1u = r1u; d1_r1a = r1a; d1_r2u = r2u; d1_r2a = r2a;
      d1_we = we; d1_wa = wa; d1_halt = hreq;
    end else begin
      d2_valid = v; d2_r1u = r1u; d2_r1a = r1a; d2_r2u = r2u; d2_r2a = r2a;
      d2_we = we; d2_wa = wa; d2_halt = hreq;
    end
    e.sel = sel; e.en = en; e.bub = bub; e.hlt = hlt; e.cnt = cnt;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs; compare at mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      string      nm;
      logic [4:0] en_a;
      logic       bub_a, hlt_a;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      en_a  = e.sel ? {d2_pc, d2_ifid, d2_idex, d2_exmem, d2_memwb}
                    : {d1_pc, d1_ifid, d1_idex, d1_exmem, d1_memwb};
      bub_a = e.sel ? d2_bub : d1_bub;
      hlt_a = e.sel ? d2_hlt : d1_hlt;
      n_tests++;
      if (en_a !== e.en) begin
        n_fail++;
        $display("FAIL %s enables: got %b expected %b (t=%0t)", nm, en_a, e.en, $time);
      end
      n_tests++;
      if (bub_a !== e.bub) begin
        n_fail++;
        $display("FAIL %s bubble: got %b expected %b (t=%0t)", nm, bub_a, e.bub, $time);
      end
      n_tests++;
      if (hlt_a !== e.hlt) begin
        n_fail++;
        $display("FAIL %s halted: got %b expected %b (t=%0t)", nm, hlt_a, e.hlt, $time);
      end
`ifdef PIPE_STALL_CNT_EN
      if (e.cnt >= 0) begin
        logic [15:0] cnt_a;
        cnt_a = e.sel ? d2_cnt : d1_cnt;
        n_tests++;
        if (cnt_a !== 16'(e.cnt)) begin
          n_fail++;
          $display("FAIL %s stall_cnt: got %0d expected %0d", nm, cnt_a, e.cnt);
        end
      end
`endif
    end
  end

  initial begin
    reset = 1'b1;
    d1_valid = 1'b0; d1_r1u = 1'b0; d1_r1a = 3'd0; d1_r2u = 1'b0; d1_r2a = 3'd0;
    d1_we = 1'b0; d1_wa = 3'd0; d1_halt = 1'b0;
    d2_valid = 1'b0; d2_r1u = 1'b0; d2_r1a = 3'd0; d2_r2u = 1'b0; d2_r2a = 3'd0;
    d2_we = 1'b0; d2_wa = 3'd0; d2_halt = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step(1'b0,1'b1,1'b0, 1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, NON,1'b1,1'b0,-1,"reset0");
    step(1'b0,1'b1,1'b0, 1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,3'd0, NON,1'b1,1'b0,-1,"reset1");

    // Independent instructions
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b1,3'd2,1'b1,3'd3, ALL,1'b0,1'b0, 0,"indep_d3");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b1,3'd2,1'b1,3'd4, ALL,1'b0,1'b0,-1,"indep_d4");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b1,3'd2,1'b1,3'd5, ALL,1'b0,1'b0,-1,"indep_d5");
    // Invalid ID slots whose fields collide with in-flight writes: no stall
    repeat (3)
      step(1'b0,1'b0,1'b0, 1'b0,1'b1,3'd3,1'b1,3'd4,1'b1,3'd3, ALL,1'b0,1'b0,-1,"nop_gated");

    // Write r3 then read r3 back-to-back: 3 stalls
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b0,3'd0,1'b1,3'd3, ALL,1'b0,1'b0,-1,"raw_w");
    repeat (3)
      step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd3,1'b0,3'd0,1'b1,3'd6, STL,1'b1,1'b0,-1,"raw_stall");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd3,1'b0,3'd0,1'b1,3'd6, ALL,1'b0,1'b0, 3,"raw_issue");

    // Write r3, unrelated, read r3 via r2: 2 stalls
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b0,3'd0,1'b1,3'd3, ALL,1'b0,1'b0,-1,"gap_w");
    step(1'b0,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b1,3'd2,1'b1,3'd4, ALL,1'b0,1'b0,-1,"gap_other");
    repeat (2)
      step(1'b0,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b1,3'd3,1'b1,3'd7, STL,1'b1,1'b0,-1,"gap_stall");
    step(1'b0,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b1,3'd3,1'b1,3'd7, ALL,1'b0,1'b0, 5,"gap_issue");

    // Register 0 is hazarded like any other; unused r1 matching r7 ignored
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b0,3'd0,1'b1,3'd0, ALL,1'b0,1'b0,-1,"r0_w");
    repeat (3)
      step(1'b0,1'b0,1'b0, 1'b1,1'b0,3'd7,1'b1,3'd0,1'b0,3'd5, STL,1'b1,1'b0,-1,"r0_stall");
    step(1'b0,1'b0,1'b0, 1'b1,1'b0,3'd7,1'b1,3'd0,1'b0,3'd5, ALL,1'b0,1'b0, 8,"r0_issue");

    // Halt with three writers in flight
    step(1'b0,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,3'd0,1'b1,3'd1, ALL,1'b0,1'b0,-1,"h_w1");
    step(1'b0,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,3'd0,1'b1,3'd2, ALL,1'b0,1'b0,-1,"h_w2");
    step(1'b0,1'b0,1'b1, 1'b1,1'b0,3'd0,1'b0,3'd0,1'b1,3'd5, ALL,1'b0,1'b0,-1,"halt_req_run");
    repeat (3)
      step(1'b0,1'b0,1'b1, 1'b1,1'b1,3'd5,1'b0,3'd0,1'b1,3'd6, STL,1'b1,1'b0,-1,"drain");
    repeat (2)
      step(1'b0,1'b0,1'b1, 1'b1,1'b1,3'd5,1'b0,3'd0,1'b1,3'd6, NON,1'b1,1'b1,-1,"halt");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd5,1'b0,3'd0,1'b1,3'd6, NON,1'b1,1'b1,-1,"halt_exit");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd5,1'b0,3'd0,1'b1,3'd6, ALL,1'b0,1'b0, 8,"resume");

    // Halt request dropped during DRAIN: back to RUN, no HALT
    step(1'b0,1'b0,1'b1, 1'b1,1'b0,3'd0,1'b0,3'd0,1'b1,3'd2, ALL,1'b0,1'b0,-1,"pulse_run");
    step(1'b0,1'b0,1'b1, 1'b1,1'b1,3'd1,1'b0,3'd0,1'b1,3'd3, STL,1'b1,1'b0,-1,"pulse_drain");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b0,3'd0,1'b1,3'd3, STL,1'b1,1'b0,-1,"pulse_drop");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd1,1'b0,3'd0,1'b1,3'd3, ALL,1'b0,1'b0, 8,"pulse_resume");

    // Reset mid-stall
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd3,1'b0,3'd0,1'b1,3'd4, STL,1'b1,1'b0, 8,"rs_stall");
    step(1'b0,1'b1,1'b0, 1'b1,1'b1,3'd3,1'b0,3'd0,1'b1,3'd4, NON,1'b1,1'b0,-1,"rs_reset");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd3,1'b0,3'd0,1'b1,3'd4, ALL,1'b0,1'b0, 0,"rs_after");

    // Reset mid-DRAIN
    step(1'b0,1'b0,1'b1, 1'b1,1'b0,3'd0,1'b0,3'd0,1'b1,3'd4, ALL,1'b0,1'b0,-1,"rd_run");
    step(1'b0,1'b0,1'b1, 1'b1,1'b1,3'd4,1'b0,3'd0,1'b1,3'd1, STL,1'b1,1'b0,-1,"rd_drain");
    step(1'b0,1'b1,1'b1, 1'b1,1'b1,3'd4,1'b0,3'd0,1'b1,3'd1, NON,1'b1,1'b0,-1,"rd_reset");
    step(1'b0,1'b0,1'b0, 1'b1,1'b1,3'd4,1'b0,3'd0,1'b1,3'd1, ALL,1'b0,1'b0, 0,"rd_after");

    // CHK_DEPTH=2 instance: back-to-back costs 2 stalls, one-gap costs 1
    step(1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,3'd0,1'b1,3'd3, ALL,1'b0,1'b0, 0,"d2_w");
    repeat (2)
      step(1'b1,1'b0,1'b0, 1'b1,1'b1,3'd3,1'b0,3'd0,1'b1,3'd6, STL,1'b1,1'b0,-1,"d2_stall");
    step(1'b1,1'b0,1'b0, 1'b1,1'b1,3'd3,1'b0,3'd0,1'b1,3'd6, ALL,1'b0,1'b0, 2,"d2_issue");
    step(1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,3'd0,1'b1,3'd3, ALL,1'b0,1'b0,-1,"d2_gap_w");
    step(1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b0,3'd0,1'b1,3'd4, ALL,1'b0,1'b0,-1,"d2_gap_other");
    step(1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b1,3'd3,1'b1,3'd7, STL,1'b1,1'b0,-1,"d2_gap_stall");
    step(1'b1,1'b0,1'b0, 1'b1,1'b0,3'd0,1'b1,3'd3,1'b1,3'd7, ALL,1'b0,1'b0, 3,"d2_gap_issue");

    // Bounded wait for the monitor to consume everything
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
